// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Imported by fetch_unit and its bench.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          PC_INC    = 4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: pc, single-outstanding imem requests,
// skid buffer and IF/ID register, with execute-stage redirect and flush.
import fetch_pkg::*;

module fetch_unit #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            Stall,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    output logic [PC_W-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic            flush
);

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic [31:0]     skid;
    logic [PC_W-1:0] target;
    logic            slot_free;
    logic            accept;
    logic            load_rdata;
    logic            load_skid;
    logic            unused_brpc;

    // Redirect target is word aligned and truncated to the pc width.
    assign target      = {BrPC[PC_W-1:2], 2'b00};
    assign unused_brpc = ^{BrPC[31:PC_W], BrPC[1:0]};

    assign slot_free = !if_valid || !Stall;
    assign imem_req  = (state == REQ) && !PcSel && reset;
    assign imem_addr = pc;
    assign accept    = imem_req && imem_ready;
    assign flush     = PcSel && reset;

    assign load_rdata = (state == WAIT) && !PcSel
                     && imem_rvalid && slot_free;
    assign load_skid  = (state == HOLD) && !PcSel && slot_free;

    // Fetch FSM: owns pc, state and the skid buffer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= REQ;
            pc    <= RESET_PC;
            skid  <= '0;
        end else begin
            unique case (state)
                REQ: begin
                    if (PcSel) begin
                        pc <= target;
                    end else if (accept) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (PcSel) begin
                        pc    <= target;
                        state <= imem_rvalid ? REQ : DRAIN;
                    end else if (load_rdata) begin
                        pc    <= pc + PC_STEP;
                        state <= REQ;
                    end else if (imem_rvalid) begin
                        skid  <= imem_rdata;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (PcSel) begin
                        pc    <= target;
                        skid  <= '0;
                        state <= REQ;
                    end else if (load_skid) begin
                        pc    <= pc + PC_STEP;
                        state <= REQ;
                    end
                end
                DRAIN: begin
                    if (PcSel) begin
                        pc <= target;
                    end
                    if (imem_rvalid) begin
                        state <= REQ;
                    end
                end
                default: begin
                    state <= REQ;
                end
            endcase
        end
    end

    // IF/ID register: redirect kills, stall holds, otherwise load or bubble.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if_valid <= 1'b0;
            if_pc    <= RESET_PC;
            if_instr <= NOP_INSTR;
        end else if (PcSel) begin
            if_valid <= 1'b0;
        end else if (load_rdata) begin
            if_valid <= 1'b1;
            if_pc    <= pc;
            if_instr <= imem_rdata;
        end else if (load_skid) begin
            if_valid <= 1'b1;
            if_pc    <= pc;
            if_instr <= skid;
        end else if (slot_free) begin
            if_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small latency-programmable
// instruction memory whose word at address a is 0xAAAA0000 | (a/4 + 1).
import fetch_pkg::*;

module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        PcSel;
    logic [31:0] BrPC;
    logic        Stall;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [8:0]  if_pc;
    logic [31:0] if_instr;
    logic        flush;

    int total;
    int bad;
    int lat;

    logic       busy;
    int         cnt;
    logic [8:0] paddr;

    fetch_unit #(.PC_W(9), .RESET_PC(9'h000)) dut (
        .clk        (clk),
        .reset      (reset),
        .PcSel      (PcSel),
        .BrPC       (BrPC),
        .Stall      (Stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .flush      (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [8:0] a);
        return 32'hAAAA_0000 | (32'(a[8:2]) + 32'd1);
    endfunction

    // Memory model: responds lat cycles after acceptance, one at a time.
    always @(posedge clk) begin
        if (!reset) begin
            busy        <= 1'b0;
            cnt         <= 0;
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'h0;
        end else begin
            imem_rvalid <= 1'b0;
            if (busy) begin
                if (cnt <= 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem_word(paddr);
                    busy        <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end else if (imem_req && imem_ready) begin
                if (lat <= 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem_word(imem_addr);
                end else begin
                    busy  <= 1'b1;
                    cnt   <= lat - 1;
                    paddr <= imem_addr;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b0;
        PcSel      = 1'b0;
        Stall      = 1'b0;
        imem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        PcSel = 1'b1;
        BrPC  = 32'h0000_0100;
        step();
        step();
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", if_valid); end
        total++; if (if_pc !== 9'h000) begin bad++; $display("FAIL rst_pc got=%h exp=000", if_pc); end
        total++; if (if_instr !== 32'h0000_0013) begin bad++; $display("FAIL rst_instr got=%h exp=00000013", if_instr); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL rst_flush got=%b exp=0", flush); end
        PcSel = 1'b0;
    endtask

    task automatic test_fetch();
        lat = 1;
        do_reset();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL f_req0 got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 9'h000) begin bad++; $display("FAIL f_addr0 got=%h exp=000", imem_addr); end
        step();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL f_req_wait got=%b exp=0", imem_req); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL f_valid_early got=%b exp=0", if_valid); end
        step();
        total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL f_valid1 got=%b exp=1", if_valid); end
        total++; if (if_pc !== 9'h000) begin bad++; $display("FAIL f_pc1 got=%h exp=000", if_pc); end
        total++; if (if_instr !== 32'hAAAA_0001) begin bad++; $display("FAIL f_instr1 got=%h exp=AAAA0001", if_instr); end
        total++; if (imem_addr !== 9'h004) begin bad++; $display("FAIL f_addr1 got=%h exp=004", imem_addr); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL f_req1 got=%b exp=1", imem_req); end
        step();
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL f_gap got=%b exp=0", if_valid); end
        step();
        total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL f_valid2 got=%b exp=1", if_valid); end
        total++; if (if_pc !== 9'h004) begin bad++; $display("FAIL f_pc2 got=%h exp=004", if_pc); end
        total++; if (if_instr !== 32'hAAAA_0002) begin bad++; $display("FAIL f_instr2 got=%h exp=AAAA0002", if_instr); end
        imem_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        lat = 3;
        do_reset();
        total++; if (imem_addr !== 9'h000) begin bad++; $display("FAIL r_addr0 got=%h exp=000", imem_addr); end
        @(negedge clk);
        PcSel = 1'b1;
        BrPC  = 32'h0000_0123;
        #1;
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL r_flush got=%b exp=1", flush); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL r_req_sup got=%b exp=0", imem_req); end
        @(negedge clk);
        PcSel = 1'b0;
        #1;
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL r_flush_off got=%b exp=0", flush); end
        total++; if (dut.state !== DRAIN) begin bad++; $display("FAIL r_drain got=%0d exp=%0d", dut.state, DRAIN); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL r_req_drain got=%b exp=0", imem_req); end
        step();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL r_req_drain2 got=%b exp=0", imem_req); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL r_stale1 got=%b exp=0", if_valid); end
        step();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL r_req_new got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 9'h120) begin bad++; $display("FAIL r_addr_new got=%h exp=120", imem_addr); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL r_stale2 got=%b exp=0", if_valid); end
        lat = 1;
        step();
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL r_stale3 got=%b exp=0", if_valid); end
        step();
        total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL r_valid got=%b exp=1", if_valid); end
        total++; if (if_pc !== 9'h120) begin bad++; $display("FAIL r_pc got=%h exp=120", if_pc); end
        total++; if (if_instr !== 32'hAAAA_0049) begin bad++; $display("FAIL r_instr got=%h exp=AAAA0049", if_instr); end
    endtask

    task automatic test_stall();
        lat = 1;
        do_reset();
        step();
        @(negedge clk);
        Stall = 1'b1;
        #1;
        total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL s_valid0 got=%b exp=1", if_valid); end
        step();
        total++; if (if_pc !== 9'h000) begin bad++; $display("FAIL s_pc_hold1 got=%h exp=000", if_pc); end
        step();
        total++; if (dut.state !== HOLD) begin bad++; $display("FAIL s_hold got=%0d exp=%0d", dut.state, HOLD); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL s_req_hold got=%b exp=0", imem_req); end
        total++; if (if_instr !== 32'hAAAA_0001) begin bad++; $display("FAIL s_instr_hold got=%h exp=AAAA0001", if_instr); end
        step();
        total++; if (dut.state !== HOLD) begin bad++; $display("FAIL s_hold2 got=%0d exp=%0d", dut.state, HOLD); end
        step();
        total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL s_valid_hold got=%b exp=1", if_valid); end
        total++; if (if_pc !== 9'h000) begin bad++; $display("FAIL s_pc_hold4 got=%h exp=000", if_pc); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL s_req_hold4 got=%b exp=0", imem_req); end
        Stall = 1'b0;
        step();
        total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL s_valid_skid got=%b exp=1", if_valid); end
        total++; if (if_pc !== 9'h004) begin bad++; $display("FAIL s_pc_skid got=%h exp=004", if_pc); end
        total++; if (if_instr !== 32'hAAAA_0002) begin bad++; $display("FAIL s_instr_skid got=%h exp=AAAA0002", if_instr); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL s_req_next got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 9'h008) begin bad++; $display("FAIL s_addr_next got=%h exp=008", imem_addr); end
    endtask

    task automatic test_wrap_and_stall_redirect();
        lat = 1;
        do_reset();
        PcSel = 1'b1;
        BrPC  = 32'h0000_05FD;
        #1;
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL w_flush got=%b exp=1", flush); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL w_req_sup got=%b exp=0", imem_req); end
        @(negedge clk);
        PcSel = 1'b0;
        #1;
        total++; if (imem_addr !== 9'h1FC) begin bad++; $display("FAIL w_addr_tgt got=%h exp=1FC", imem_addr); end
        step();
        step();
        total++; if (if_pc !== 9'h1FC) begin bad++; $display("FAIL w_pc got=%h exp=1FC", if_pc); end
        total++; if (if_instr !== 32'hAAAA_0080) begin bad++; $display("FAIL w_instr got=%h exp=AAAA0080", if_instr); end
        total++; if (imem_addr !== 9'h000) begin bad++; $display("FAIL w_wrap got=%h exp=000", imem_addr); end
        total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL sr_valid0 got=%b exp=1", if_valid); end
        Stall = 1'b1;
        PcSel = 1'b1;
        BrPC  = 32'h0000_0040;
        #1;
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL sr_flush got=%b exp=1", flush); end
        @(negedge clk);
        PcSel = 1'b0;
        #1;
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL sr_kill got=%b exp=0", if_valid); end
        total++; if (imem_addr !== 9'h040) begin bad++; $display("FAIL sr_addr got=%h exp=040", imem_addr); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL sr_req got=%b exp=1", imem_req); end
        step();
        step();
        total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL sr_valid got=%b exp=1", if_valid); end
        total++; if (if_pc !== 9'h040) begin bad++; $display("FAIL sr_pc got=%h exp=040", if_pc); end
        total++; if (if_instr !== 32'hAAAA_0011) begin bad++; $display("FAIL sr_instr got=%h exp=AAAA0011", if_instr); end
        Stall = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        lat = 1;
        do_reset();
        step();
        @(negedge clk);
        lat   = 3;
        Stall = 1'b1;
        #1;
        step();
        total++; if (dut.state !== WAIT) begin bad++; $display("FAIL m_wait got=%0d exp=%0d", dut.state, WAIT); end
        total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL m_valid got=%b exp=1", if_valid); end
        reset = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL m_req_rst got=%b exp=0", imem_req); end
        step();
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL m_valid_rst got=%b exp=0", if_valid); end
        total++; if (if_instr !== 32'h0000_0013) begin bad++; $display("FAIL m_instr_rst got=%h exp=00000013", if_instr); end
        total++; if (if_pc !== 9'h000) begin bad++; $display("FAIL m_pc_rst got=%h exp=000", if_pc); end
        total++; if (dut.state !== REQ) begin bad++; $display("FAIL m_state_rst got=%0d exp=%0d", dut.state, REQ); end
        Stall = 1'b0;
        lat   = 1;
        reset = 1'b1;
        #1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL m_req_rel got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 9'h000) begin bad++; $display("FAIL m_addr_rel got=%h exp=000", imem_addr); end
        step();
        step();
        total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL m_valid_rel got=%b exp=1", if_valid); end
        total++; if (if_instr !== 32'hAAAA_0001) begin bad++; $display("FAIL m_instr_rel got=%h exp=AAAA0001", if_instr); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        lat        = 1;
        reset      = 1'b0;
        PcSel      = 1'b0;
        BrPC       = 32'h0;
        Stall      = 1'b0;
        imem_ready = 1'b1;
        test_reset();
        test_fetch();
        test_redirect_wait();
        test_stall();
        test_wrap_and_stall_redirect();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end at the consuming end of the branch/jump redirect interface. Holds the program counter and issues single-outstanding requests to instruction memory. Presents fetched instructions to the IF/ID register. Takes the execute-stage redirect (`PcSel`, `BrPC`) and the hazard-unit stall, and raises a flush when a redirect squashes younger work.

## Interface
- `PC_W`, 9, program counter width in bits (byte address).
- `RESET_PC`, 0, PC value loaded at reset.
- `clk` in 1: the block's single clock.
- `reset` in 1: synchronous, active-low reset.
- `PcSel` in 1: redirect request from execute; 1 means branch taken, jal or jalr.
- `BrPC` in 32: redirect target; valid when `PcSel`=1.
- `Stall` in 1: hazard-unit stall; IF/ID must hold its contents.
- `imem_req` out 1: a request is presented to instruction memory.
- `imem_addr` out PC_W: request address, equal to the current PC.
- `imem_ready` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: response data valid; arrives at least 1 cycle after acceptance.
- `imem_rdata` in 32: instruction word.
- `if_valid` out 1: the IF/ID payload is valid.
- `if_pc` out PC_W: PC of the presented instruction.
- `if_instr` out 32: the presented instruction.
- `flush` out 1: kill IF/ID and ID/EX contents at the next edge.

## Operation
- States (package enum): `REQ`, `WAIT`, `HOLD`, `DRAIN`. Reset state is `REQ`.
- Handshake: a request is accepted when `imem_req && imem_ready`. At most one request is outstanding.
- `imem_req` = (state==`REQ`) && !`PcSel` && `reset`. A redirect suppresses acceptance in that cycle.
- "Slot free" means !`if_valid` || !`Stall`.
- REQ state:
  - If `PcSel`: pc <= target; stay in `REQ`.
  - Else, on acceptance: go to `WAIT`.
- WAIT state:
  - If `PcSel`: pc <= target. Go to `REQ` if `imem_rvalid` is high this cycle (the data is discarded); otherwise go to `DRAIN`.
  - Else if `imem_rvalid` and slot free: load `if_instr`=`imem_rdata`, `if_pc`=pc, `if_valid`=1; pc <= pc+4; go to `REQ`.
  - Else if `imem_rvalid` and slot blocked: capture the data into the skid register; go to `HOLD`.
- HOLD state:
  - If `PcSel`: drop the skid data, pc <= target, go to `REQ`.
  - Else if slot free: move the skid data into IF/ID (`if_pc`=pc); pc <= pc+4; go to `REQ`.
- DRAIN state:
  - When `imem_rvalid` arrives, discard the data and go to `REQ`.
  - A `PcSel` during `DRAIN` updates pc and the state stays `DRAIN`.
- Target = `BrPC[PC_W-1:0]` with bits [1:0] forced to 0.
- pc+4 wraps modulo 2^PC_W.
- `flush` = `PcSel` (combinational). In the same edge, `if_valid` <= 0, overriding `Stall` and any load.
- When `Stall` is high and `if_valid` is high, all IF/ID outputs hold their values.

## Timing
- Reset values while `reset`=0: `if_valid`=0, `if_pc`=`RESET_PC`, `if_instr`=32'h00000013 (NOP), `imem_req`=0, `flush`=0, pc=`RESET_PC`, skid cleared.
- Instruction memory is reset by the same reset. No stale response follows reset, so a reset mid-`WAIT` or mid-`DRAIN` simply returns the block to `REQ`.
- First request: `imem_req`=1 in the first cycle after `reset` goes high.
- Latency with a 1-cycle memory is request accepted at cycle N, then `if_valid`=1 from edge N+2. Throughput is 1 instruction per 2 cycles.
- Redirect: target appears on `imem_addr` in the cycle after `PcSel`. This holds from every state except `DRAIN`, where it appears one cycle after the drained `imem_rvalid`.
- Simultaneous `PcSel` and `Stall`: the redirect wins.
- Simultaneous `PcSel` and `imem_rvalid` in `WAIT`: the data is dropped and nothing is presented.

## Structure
- `fetch_pkg` holds the state enum, the `NOP_INSTR` constant (32'h00000013), and the `PC_INC` constant (4).
- The single module contains the FSM, the pc register, the skid register and the IF/ID output register. No sub-module is warranted.

## Test plan
- Reset release with `RESET_PC`=0 and 1-cycle memory returning 0xAAAA0001, 0xAAAA0002 → `imem_addr` 0, then 4. IF/ID presents (0, 0xAAAA0001) then (4, 0xAAAA0002), with `if_valid` pulses 2 cycles apart.
- `PcSel`=1 with `BrPC`=0x0000_0123 while in `WAIT` with the response delayed 3 cycles → `flush`=1 that cycle and the late response is discarded. Next request is to 0x120; no instruction from the old pc appears.
- `Stall`=1 held 4 cycles while a response arrives → IF/ID is unchanged, the state is `HOLD`, and `imem_req`=0. After `Stall` drops, the skid instruction is presented the next cycle, followed by a request for pc+4.
- PC=0x1FC with `PC_W`=9 → next fetch address is 0x000 (wrap).
- `PcSel` and `Stall` both high with `if_valid`=1 → `if_valid`=0 next cycle and the target is fetched.
- `reset`=0 asserted mid-`WAIT` → all outputs take their reset values next edge. After release, the first request is to `RESET_PC`.
